// File: rtl/tex_dcr_ctrl_pkg.sv
// Texture DCR types, address map and the per-stage field decoder shared by the controller.
package tex_dcr_ctrl_pkg;

    localparam int unsigned DCR_ADDR_BITS    = 12;
    localparam int unsigned TEX_STAGE_COUNT  = 2;
    localparam int unsigned TEX_STAGE_BITS   = 3;
    localparam int unsigned TEX_LOD_BITS     = 4;
    localparam int unsigned TEX_LOD_MAX      = 11;
    localparam int unsigned TEX_LOD_IDX_BITS = 4;
    localparam int unsigned TEX_MIPOFF_BITS  = 24;
    localparam int unsigned TEX_FORMAT_BITS  = 3;
    localparam int unsigned TEX_WRAP_BITS    = 2;

    typedef logic [DCR_ADDR_BITS-1:0] dcr_addr_t;

    localparam dcr_addr_t DCR_TEX_BASE        = 12'h100;
    localparam dcr_addr_t DCR_TEX_STAGE       = DCR_TEX_BASE;
    localparam dcr_addr_t DCR_TEX_ADDR        = DCR_TEX_BASE + 12'd1;
    localparam dcr_addr_t DCR_TEX_LOGDIM      = DCR_TEX_BASE + 12'd2;
    localparam dcr_addr_t DCR_TEX_FORMAT      = DCR_TEX_BASE + 12'd3;
    localparam dcr_addr_t DCR_TEX_FILTER      = DCR_TEX_BASE + 12'd4;
    localparam dcr_addr_t DCR_TEX_WRAP        = DCR_TEX_BASE + 12'd5;
    localparam dcr_addr_t DCR_TEX_MIPOFF      = DCR_TEX_BASE + 12'd6;
    localparam dcr_addr_t TEX_DCR_MIPOFF_LAST = dcr_addr_t'(DCR_TEX_MIPOFF + TEX_LOD_MAX);

    typedef struct packed {
        logic [31:0]                                   baddr;
        logic [1:0][TEX_LOD_BITS-1:0]                  logdims;
        logic [TEX_FORMAT_BITS-1:0]                    format;
        logic                                          filter;
        logic [1:0][TEX_WRAP_BITS-1:0]                 wraps;
        logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]     mipoff;
    } tex_dcrs_t;

    function automatic int unsigned log2up(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Applies one non-stage texture DCR write to a stage record; unknown addresses leave it untouched.
    function automatic tex_dcrs_t tex_dcr_update(tex_dcrs_t cur, dcr_addr_t addr, logic [31:0] data);
        tex_dcrs_t nxt;
        nxt = cur;
        case (addr)
            DCR_TEX_ADDR:   nxt.baddr = data;
            DCR_TEX_LOGDIM: begin
                nxt.logdims[0] = data[TEX_LOD_BITS-1:0];
                nxt.logdims[1] = data[16 +: TEX_LOD_BITS];
            end
            DCR_TEX_FORMAT: nxt.format = data[TEX_FORMAT_BITS-1:0];
            DCR_TEX_FILTER: nxt.filter = data[0];
            DCR_TEX_WRAP: begin
                nxt.wraps[0] = data[1:0];
                nxt.wraps[1] = data[17:16];
            end
            default: begin
                if (addr >= DCR_TEX_MIPOFF && addr <= TEX_DCR_MIPOFF_LAST)
                    nxt.mipoff[TEX_LOD_IDX_BITS'(addr - DCR_TEX_MIPOFF)] = data[TEX_MIPOFF_BITS-1:0];
            end
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/tex_dcr_ctrl_if.sv
// DCR write bus plus texture-unit lookup request/response bundle.
interface tex_dcr_ctrl_if import tex_dcr_ctrl_pkg::*; #(
    parameter int unsigned NUM_REQS = 4
);
    localparam int unsigned REQ_BITS = log2up(NUM_REQS);

    logic                               dcr_wr_valid;
    dcr_addr_t                          dcr_wr_addr;
    logic [31:0]                        dcr_wr_data;
    logic [NUM_REQS-1:0]                req_valid;
    logic [NUM_REQS*TEX_STAGE_BITS-1:0] req_stage;
    logic [NUM_REQS-1:0]                req_ready;
    logic                               rsp_valid;
    logic [REQ_BITS-1:0]                rsp_idx;
    tex_dcrs_t                          rsp_dcrs;
    logic                               rsp_ready;

    modport master (
        output dcr_wr_valid, dcr_wr_addr, dcr_wr_data, req_valid, req_stage, rsp_ready,
        input  req_ready, rsp_valid, rsp_idx, rsp_dcrs
    );

    modport slave (
        input  dcr_wr_valid, dcr_wr_addr, dcr_wr_data, req_valid, req_stage, rsp_ready,
        output req_ready, rsp_valid, rsp_idx, rsp_dcrs
    );
endinterface

// File: rtl/tex_dcr_ctrl_rr_arbiter.sv
// Round-robin arbiter; priority rotates past the last requester that actually handshook.
module tex_dcr_ctrl_rr_arbiter #(
    parameter int unsigned NUM_REQS = 4,
    parameter int unsigned REQ_BITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_REQS-1:0] requests,
    input  logic                enable,
    input  logic                unlock,
    output logic [NUM_REQS-1:0] grant_c,
    output logic [REQ_BITS-1:0] grant_idx_c
);

    logic [REQ_BITS-1:0] last_grant_q, last_grant_d;
    logic [REQ_BITS-1:0] cand_c;
    logic                found_c;

    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int unsigned i = 1; i <= NUM_REQS; i++) begin
            cand_c = REQ_BITS'((32'(last_grant_q) + i) % NUM_REQS);
            if (!found_c && requests[cand_c]) begin
                found_c     = 1'b1;
                grant_idx_c = cand_c;
            end
        end
    end

    always_comb begin
        grant_c      = (found_c && enable) ? (NUM_REQS'(1) << grant_idx_c) : '0;
        last_grant_d = unlock ? grant_idx_c : last_grant_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant_q <= REQ_BITS'(NUM_REQS - 1);
        else          last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/tex_dcr_ctrl.sv
// Per-stage texture DCR storage with a round-robin arbitrated, registered lookup port.
module tex_dcr_ctrl import tex_dcr_ctrl_pkg::*; #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned STAGE_COUNT = TEX_STAGE_COUNT,
    parameter int unsigned REQ_BITS    = log2up(NUM_REQS)
) (
    input  logic           clk,
    input  logic           reset_n,
    tex_dcr_ctrl_if.slave  bus
);

    logic [TEX_STAGE_BITS-1:0] wr_stage_q, wr_stage_d;
    tex_dcrs_t                 dcrs_q [STAGE_COUNT];
    tex_dcrs_t                 dcrs_d [STAGE_COUNT];
    logic                      rsp_valid_q, rsp_valid_d;
    logic [REQ_BITS-1:0]       rsp_idx_q, rsp_idx_d;
    tex_dcrs_t                 rsp_dcrs_q, rsp_dcrs_d;

    logic [NUM_REQS-1:0]       grant_c;
    logic [REQ_BITS-1:0]       grant_idx_c;
    logic                      arb_en_c;
    logic                      handshake_c;
    logic [TEX_STAGE_BITS-1:0] grant_stage_c;
    logic [TEX_STAGE_BITS-1:0] dcr_stage_c;
    tex_dcrs_t                 rd_dcrs_c;

    assign dcr_stage_c = bus.dcr_wr_data[TEX_STAGE_BITS-1:0];

    // DCR decode: stage pointer writes are range-checked, everything else lands in the current stage.
    always_comb begin
        wr_stage_d = wr_stage_q;
        dcrs_d     = dcrs_q;
        if (bus.dcr_wr_valid) begin
            if (bus.dcr_wr_addr == DCR_TEX_STAGE) begin
                if (32'(dcr_stage_c) < STAGE_COUNT) wr_stage_d = dcr_stage_c;
            end else begin
                for (int unsigned s = 0; s < STAGE_COUNT; s++) begin
                    if (wr_stage_q == TEX_STAGE_BITS'(s))
                        dcrs_d[s] = tex_dcr_update(dcrs_q[s], bus.dcr_wr_addr, bus.dcr_wr_data);
                end
            end
        end
    end

    // A new grant is only offered when the response slot is free or being drained this cycle.
    assign arb_en_c = reset_n && (!rsp_valid_q || bus.rsp_ready);

    tex_dcr_ctrl_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .REQ_BITS (REQ_BITS)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .requests    (bus.req_valid),
        .enable      (arb_en_c),
        .unlock      (handshake_c),
        .grant_c     (grant_c),
        .grant_idx_c (grant_idx_c)
    );

    assign bus.req_ready = grant_c;
    assign handshake_c   = |(bus.req_valid & grant_c);
    assign grant_stage_c = bus.req_stage[32'(grant_idx_c) * TEX_STAGE_BITS +: TEX_STAGE_BITS];

    // Read mux from the registered array, so same-cycle writes are not bypassed; out-of-range reads zero.
    always_comb begin
        rd_dcrs_c = '0;
        for (int unsigned s = 0; s < STAGE_COUNT; s++) begin
            if (grant_stage_c == TEX_STAGE_BITS'(s)) rd_dcrs_c = dcrs_q[s];
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_dcrs_d  = rsp_dcrs_q;
        if (handshake_c) begin
            rsp_valid_d = 1'b1;
            rsp_idx_d   = grant_idx_c;
            rsp_dcrs_d  = rd_dcrs_c;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_stage_q  <= '0;
            dcrs_q      <= '{default: '0};
            rsp_valid_q <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_dcrs_q  <= '0;
        end else begin
            wr_stage_q  <= wr_stage_d;
            dcrs_q      <= dcrs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_dcrs_q  <= rsp_dcrs_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_dcrs  = rsp_dcrs_q;

endmodule

// File: tb/tb_tex_dcr_ctrl.sv
// Directed plus randomized bench for tex_dcr_ctrl against a field-level model of the stage table.
module tb_tex_dcr_ctrl;
    import tex_dcr_ctrl_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned NS = TEX_STAGE_COUNT;
    localparam int unsigned NM = TEX_LOD_MAX + 1;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    tex_dcr_ctrl_if #(.NUM_REQS(N)) bus ();

    tex_dcr_ctrl #(.NUM_REQS(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain per-field arrays plus the expected response slot.
    logic [31:0] m_baddr [NS];
    logic [3:0]  m_lod   [NS][2];
    logic [2:0]  m_fmt   [NS];
    logic        m_filt  [NS];
    logic [1:0]  m_wrap  [NS][2];
    logic [23:0] m_mip   [NS][NM];
    int          m_wr_stage;
    int          m_last;
    bit          m_rsp_valid;
    int          m_rsp_idx;
    tex_dcrs_t   m_rsp_dcrs;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int s = 0; s < NS; s++) begin
            m_baddr[s] = '0; m_fmt[s] = '0; m_filt[s] = 1'b0;
            for (int k = 0; k < 2; k++) begin m_lod[s][k] = '0; m_wrap[s][k] = '0; end
            for (int n = 0; n < NM; n++) m_mip[s][n] = '0;
        end
        m_wr_stage  = 0;
        m_last      = N - 1;
        m_rsp_valid = 1'b0;
        m_rsp_idx   = 0;
        m_rsp_dcrs  = '0;
    endfunction

    function automatic void m_write(input int addr, input logic [31:0] d);
        int off;
        int s;
        off = addr - int'(DCR_TEX_BASE);
        s   = m_wr_stage;
        if (off == 0) begin
            if (int'(d[TEX_STAGE_BITS-1:0]) < NS) m_wr_stage = int'(d[TEX_STAGE_BITS-1:0]);
        end
        else if (off == 1) m_baddr[s] = d;
        else if (off == 2) begin m_lod[s][0] = d[3:0]; m_lod[s][1] = d[19:16]; end
        else if (off == 3) m_fmt[s] = d[2:0];
        else if (off == 4) m_filt[s] = d[0];
        else if (off == 5) begin m_wrap[s][0] = d[1:0]; m_wrap[s][1] = d[17:16]; end
        else if (off >= 6 && off < 6 + NM) m_mip[s][off-6] = d[23:0];
    endfunction

    function automatic tex_dcrs_t exp_dcrs(input int s);
        tex_dcrs_t r;
        r = '0;
        if (s < NS) begin
            r.baddr = m_baddr[s];
            r.logdims[0] = m_lod[s][0]; r.logdims[1] = m_lod[s][1];
            r.format = m_fmt[s];
            r.filter = m_filt[s];
            r.wraps[0] = m_wrap[s][0]; r.wraps[1] = m_wrap[s][1];
            for (int n = 0; n < NM; n++) r.mipoff[n] = m_mip[s][n];
        end
        return r;
    endfunction

    task automatic drv_idle();
        bus.dcr_wr_valid = 1'b0;
        bus.dcr_wr_addr  = '0;
        bus.dcr_wr_data  = '0;
        bus.req_valid    = '0;
        bus.req_stage    = '0;
        bus.rsp_ready    = 1'b1;
    endtask

    // Called at a negedge with inputs applied; checks this cycle, advances the model, returns at the next negedge.
    task automatic step();
        logic [N-1:0] exp_ready;
        int g;
        int c;
        #1;
        exp_ready = '0;
        g = -1;
        if (!(m_rsp_valid && !bus.rsp_ready)) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 512'(bus.req_ready), 512'(exp_ready));
        chk("rsp_valid", 512'(bus.rsp_valid), 512'(m_rsp_valid));
        if (m_rsp_valid) begin
            chk("rsp_idx", 512'(bus.rsp_idx), 512'(m_rsp_idx));
            chk("rsp_dcrs", 512'(bus.rsp_dcrs), 512'(m_rsp_dcrs));
        end
        if (g >= 0) begin
            m_rsp_valid = 1'b1;
            m_rsp_idx   = g;
            m_rsp_dcrs  = exp_dcrs(int'(bus.req_stage[g*TEX_STAGE_BITS +: TEX_STAGE_BITS]));
            m_last      = g;
        end else if (bus.rsp_ready) begin
            m_rsp_valid = 1'b0;
        end
        if (bus.dcr_wr_valid) m_write(int'(bus.dcr_wr_addr), bus.dcr_wr_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input dcr_addr_t a, input logic [31:0] d);
        drv_idle();
        bus.dcr_wr_valid = 1'b1;
        bus.dcr_wr_addr  = a;
        bus.dcr_wr_data  = d;
        step();
        drv_idle();
    endtask

    task automatic lookup(input int u, input int s);
        drv_idle();
        bus.req_valid[u] = 1'b1;
        bus.req_stage[u*TEX_STAGE_BITS +: TEX_STAGE_BITS] = TEX_STAGE_BITS'(s);
        step();
        drv_idle();
    endtask

    initial begin
        int last0;
        int hold_idx;
        reset_n = 1'b0;
        drv_idle();
        bus.req_valid = '1;
        m_reset();
        #2;
        chk("reset_req_ready", 512'(bus.req_ready), 512'(0));
        chk("reset_rsp_valid", 512'(bus.rsp_valid), 512'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        drv_idle();

        lookup(2, 0);
        chk("first_valid", 512'(bus.rsp_valid), 512'(1));
        chk("first_idx", 512'(bus.rsp_idx), 512'(2));
        chk("first_dcrs", 512'(bus.rsp_dcrs), 512'(0));

        wr(DCR_TEX_STAGE, 32'd1);
        wr(DCR_TEX_ADDR, 32'h8000_0000);
        wr(DCR_TEX_LOGDIM, 32'h0005_0007);
        lookup(1, 1);
        chk("s1_baddr", 512'(bus.rsp_dcrs.baddr), 512'(32'h8000_0000));
        chk("s1_lod0", 512'(bus.rsp_dcrs.logdims[0]), 512'(7));
        chk("s1_lod1", 512'(bus.rsp_dcrs.logdims[1]), 512'(5));
        lookup(0, 0);
        chk("s0_zero", 512'(bus.rsp_dcrs), 512'(0));

        wr(DCR_TEX_STAGE, 32'd5);
        wr(DCR_TEX_FORMAT, 32'd3);
        lookup(0, 1);
        chk("s1_format", 512'(bus.rsp_dcrs.format), 512'(3));
        lookup(0, 0);
        chk("s0_format", 512'(bus.rsp_dcrs.format), 512'(0));

        for (int n = 0; n < NM; n++) wr(dcr_addr_t'(DCR_TEX_MIPOFF + n), 32'h10 + n);
        wr(dcr_addr_t'(DCR_TEX_MIPOFF + NM), 32'hFF);
        lookup(3, 1);
        for (int n = 0; n < NM; n++)
            chk($sformatf("mipoff%0d", n), 512'(bus.rsp_dcrs.mipoff[n]), 512'(32'h10 + n));
        chk("mip_baddr_kept", 512'(bus.rsp_dcrs.baddr), 512'(32'h8000_0000));
        chk("mip_format_kept", 512'(bus.rsp_dcrs.format), 512'(3));
        lookup(1, 5);
        chk("oob_stage_zero", 512'(bus.rsp_dcrs), 512'(0));

        drv_idle();
        bus.req_valid = '1;
        last0 = m_last;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_order", 512'(bus.rsp_idx), 512'((last0 + 1 + k) % N));
        end

        step();
        hold_idx = (last0 + 6) % N;
        chk("bp_loaded", 512'(bus.rsp_idx), 512'(hold_idx));
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_idx", 512'(bus.rsp_idx), 512'(hold_idx));
            chk("bp_hold_valid", 512'(bus.rsp_valid), 512'(1));
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_release", 512'(bus.rsp_idx), 512'((hold_idx + 1) % N));
        drv_idle();

        wr(DCR_TEX_STAGE, 32'd0);
        bus.dcr_wr_valid = 1'b1;
        bus.dcr_wr_addr  = DCR_TEX_FORMAT;
        bus.dcr_wr_data  = 32'd2;
        bus.req_valid[0] = 1'b1;
        step();
        chk("nobypass_old", 512'(bus.rsp_dcrs.format), 512'(0));
        lookup(0, 0);
        chk("nobypass_new", 512'(bus.rsp_dcrs.format), 512'(2));

        lookup(1, 1);
        bus.req_valid = '1;
        reset_n = 1'b0;
        #1;
        chk("midreset_valid", 512'(bus.rsp_valid), 512'(0));
        chk("midreset_ready", 512'(bus.req_ready), 512'(0));
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drv_idle();
        lookup(0, 1);
        chk("post_reset_clear", 512'(bus.rsp_dcrs), 512'(0));

        for (int k = 0; k < 1500; k++) begin
            drv_idle();
            if ($urandom_range(0, 2) == 0) begin
                bus.dcr_wr_valid = 1'b1;
                if ($urandom_range(0, 9) == 0) bus.dcr_wr_addr = dcr_addr_t'($urandom_range(0, 255));
                else bus.dcr_wr_addr = dcr_addr_t'(DCR_TEX_BASE + $urandom_range(0, 19));
                bus.dcr_wr_data = (bus.dcr_wr_addr == DCR_TEX_STAGE) ? 32'($urandom_range(0, 3)) : $urandom;
            end
            bus.req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int u = 0; u < N; u++)
                bus.req_stage[u*TEX_STAGE_BITS +: TEX_STAGE_BITS] = TEX_STAGE_BITS'($urandom_range(0, 3));
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
